// File: rtl/cpa_pipe.sv
// Pipelined carry-propagate adder/subtractor.
//
// Operands are split into SEG-bit segments; stage k ripple-adds segment k and registers its
// carry for stage k+1. Operands travel alongside the partial sum so each stage finds its own
// segment. A result accepted at edge t is presented after edge t+N-1 (N = WIDTH/SEG stages).
//
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   in_valid / in_ready   operand handshake; in_ready = ~out_valid | out_ready
//   num1, num2            operands A and B
//   cin                   carry-in, ignored when sub=1
//   sub                   0: A+B+cin, 1: A-B
//   out_valid / out_ready result handshake
//   out, cout, ovf        sum mod 2^WIDTH, MSB carry-out (1 = no borrow on sub), signed overflow
module cpa_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SEG   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] num1,
  input  logic [WIDTH-1:0] num2,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned N = WIDTH / SEG;

  // Stage registers: valid, operand copies, partial sum, segment carry.
  logic [N-1:0]     valid_q;
  logic [WIDTH-1:0] a_q [N];
  logic [WIDTH-1:0] b_q [N];
  logic [WIDTH-1:0] s_q [N];
  logic [N-1:0]     c_q;
  logic             ovf_q;

  logic             en;

  // Per-stage inputs (from the stage below, or the conditioned operands for stage 0).
  logic [WIDTH-1:0] a_in [N];
  logic [WIDTH-1:0] b_in [N];
  logic [WIDTH-1:0] s_in [N];
  logic [N-1:0]     c_in;
  logic [SEG:0]     seg_sum [N];
  logic [WIDTH-1:0] s_d [N];
  logic             ovf_d;

  assign en       = ~out_valid | out_ready;
  assign in_ready = en;

  always_comb begin
    a_in[0] = num1;
    b_in[0] = sub ? ~num2 : num2;
    s_in[0] = '0;
    c_in[0] = sub ? 1'b1 : cin;
    for (int unsigned k = 1; k < N; k++) begin
      a_in[k] = a_q[k-1];
      b_in[k] = b_q[k-1];
      s_in[k] = s_q[k-1];
      c_in[k] = c_q[k-1];
    end
    for (int unsigned k = 0; k < N; k++) begin
      seg_sum[k] = {1'b0, a_in[k][k*SEG +: SEG]} + {1'b0, b_in[k][k*SEG +: SEG]}
                 + {{SEG{1'b0}}, c_in[k]};
      s_d[k] = s_in[k];
      s_d[k][k*SEG +: SEG] = seg_sum[k][SEG-1:0];
    end
    // Carry into the MSB is recovered from the MSB sum bit: s = a ^ b ^ c.
    ovf_d = (a_in[N-1][WIDTH-1] ^ b_in[N-1][WIDTH-1] ^ seg_sum[N-1][SEG-1])
          ^ seg_sum[N-1][SEG];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      c_q     <= '0;
      ovf_q   <= 1'b0;
      for (int unsigned k = 0; k < N; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else if (en) begin
      valid_q[0] <= in_valid;
      for (int unsigned k = 1; k < N; k++) begin
        valid_q[k] <= valid_q[k-1];
      end
      for (int unsigned k = 0; k < N; k++) begin
        a_q[k] <= a_in[k];
        b_q[k] <= b_in[k];
        s_q[k] <= s_d[k];
        c_q[k] <= seg_sum[k][SEG];
      end
      ovf_q <= ovf_d;
    end
  end

  assign out_valid = valid_q[N-1];
  assign out       = s_q[N-1];
  assign cout      = c_q[N-1];
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_cpa_pipe.sv
module tb_cpa_pipe;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned SEG   = 8;
  localparam int          N     = WIDTH / SEG;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] num1;
  logic [WIDTH-1:0] num2;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             cout;
  logic             ovf;

  cpa_pipe #(.WIDTH(WIDTH), .SEG(SEG)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .num1      (num1),
    .num2      (num2),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] out;
    logic             cout;
    logic             ovf;
    int               acc;
    int               stalls;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   stalls = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values.
  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic c, input logic s);
    exp_t   e;
    longint sa, sb_v, r;
    longint unsigned ua, ub, ur;
    ua = longint'(a);
    ub = longint'(b);
    sa = longint'($signed(a));
    sb_v = longint'($signed(b));
    if (s) begin
      ur = ua - ub;
      e.cout = (ua >= ub);
      r = sa - sb_v;
    end else begin
      ur = ua + ub + longint'(c);
      e.cout = (ur >= 64'h1_0000_0000);
      r = sa + sb_v + longint'(c);
    end
    e.out = ur[WIDTH-1:0];
    e.ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
    e.acc = 0;
    e.stalls = 0;
    return e;
  endfunction

  // Presents one operation and pushes its expected result once accepted.
  task automatic issue_exp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c,
                           input logic s, input exp_t e);
    bit done = 0;
    in_valid = 1'b1;
    num1 = a;
    num2 = b;
    cin = c;
    sub = s;
    for (int w = 0; w < 50 && !done; w++) begin
      @(negedge clk);
      if (in_ready) begin
        e.acc = cyc;
        e.stalls = stalls;
        sb.push_back(e);
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) chk("accept_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c,
                       input logic s);
    issue_exp(a, b, c, s, model(a, b, c, s));
  endtask

  function automatic exp_t mk(input logic [WIDTH-1:0] o, input logic co, input logic ov);
    exp_t e;
    e.out = o;
    e.cout = co;
    e.ovf = ov;
    e.acc = 0;
    e.stalls = 0;
    return e;
  endfunction

  // Monitor: samples on the falling edge, a transfer happens on the following rising edge.
  logic [WIDTH-1:0] prev_out;
  logic             prev_cout, prev_ovf;
  bit               have_prev = 0;

  always @(negedge clk) begin
    if (rst) begin
      have_prev = 0;
    end else begin
      if (out_valid && !out_ready) begin
        stalls++;
        chk("in_ready_stall", in_ready, 0);
        if (have_prev) begin
          chk("hold_out", out, prev_out);
          chk("hold_cout", cout, prev_cout);
          chk("hold_ovf", ovf, prev_ovf);
        end
        prev_out = out;
        prev_cout = cout;
        prev_ovf = ovf;
        have_prev = 1;
      end else begin
        have_prev = 0;
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_result", out_valid, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("out", out, e.out);
          chk("cout", cout, e.cout);
          chk("ovf", ovf, e.ovf);
          if (e.stalls == stalls) chk("latency", cyc - e.acc, N);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    num1 = 32'h1234_5678;
    num2 = 32'h0000_0001;
    cin = 1'b1;
    sub = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out", out, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;

    // Directed corners.
    issue_exp(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, mk(32'h0000_0000, 1'b1, 1'b0));
    repeat (6) @(posedge clk);
    #1;
    issue_exp(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, mk(32'hFFFF_FFFE, 1'b0, 1'b0));
    issue_exp(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, mk(32'h7FFF_FFFF, 1'b1, 1'b1));
    issue_exp(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, mk(32'h8000_0000, 1'b0, 1'b1));

    // Back-to-back random stream.
    for (int i = 0; i < 100; i++) begin
      issue($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Stream with a 3-cycle output stall in the middle.
    for (int i = 0; i < 20; i++) begin
      if (i == 8) begin
        fork
          begin
            out_ready = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            out_ready = 1'b1;
          end
        join_none
      end
      issue($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    repeat (8) @(posedge clk);
    #1;

    // Reset with three operations in flight: none may emerge.
    for (int i = 0; i < 3; i++) begin
      issue($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    rst = 1'b1;
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    issue(32'hDEAD_BEEF, 32'h1111_1111, 1'b1, 1'b0);

    // Drain with a bounded wait.
    for (int w = 0; w < 200 && sb.size() != 0; w++) @(posedge clk);
    repeat (10) @(posedge clk);
    chk("scoreboard_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
